// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: Clk/2 pixel clock, DrawX/DrawY scan counters and
// registered syncs/blank from two-process FSMs. Define VGA_FRAME_COUNT_EN to build the frame counter.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int H_VIS = 640,
    parameter int H_FP  = 16,
    parameter int H_SW  = 96,
    parameter int H_BP  = 48,
    parameter int V_VIS = 480,
    parameter int V_FP  = 10,
    parameter int V_SW  = 2,
    parameter int V_BP  = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_clk,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam logic [9:0] X_FRONT = 10'(H_VIS);
    localparam logic [9:0] X_SYNC  = 10'(H_VIS + H_FP);
    localparam logic [9:0] X_BACK  = 10'(H_VIS + H_FP + H_SW);
    localparam logic [9:0] X_LAST  = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] Y_FRONT = 10'(V_VIS);
    localparam logic [9:0] Y_SYNC  = 10'(V_VIS + V_FP);
    localparam logic [9:0] Y_BACK  = 10'(V_VIS + V_FP + V_SW);
    localparam logic [9:0] Y_LAST  = 10'(V_VIS + V_FP + V_SW + V_BP - 1);

    typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC, H_BACK} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC, V_BACK} v_state_t;

    h_state_t   h_state_reg, h_state_next;
    v_state_t   v_state_reg, v_state_next;
    logic       pclk_reg;
    logic [9:0] x_reg, x_next, y_reg, y_next;
    logic       hs_reg, vs_reg, blank_reg, frame_start_reg;
    logic       line_end, frame_wrap, state_bad;

    always_comb begin
        h_state_next = h_state_reg;
        v_state_next = v_state_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        line_end     = 1'b0;
        frame_wrap   = 1'b0;
        state_bad    = 1'b0;
        if (pclk_reg) begin
            line_end   = (x_reg == X_LAST);
            frame_wrap = line_end && (y_reg == Y_LAST);
            x_next     = line_end ? 10'd0 : x_reg + 10'd1;
            if (line_end)
                y_next = (y_reg == Y_LAST) ? 10'd0 : y_reg + 10'd1;

            case (h_state_reg)
                H_ACT:   if (x_next == X_FRONT) h_state_next = H_FRONT;
                H_FRONT: if (x_next == X_SYNC)  h_state_next = H_SYNC;
                H_SYNC:  if (x_next == X_BACK)  h_state_next = H_BACK;
                H_BACK:  if (line_end)          h_state_next = H_ACT;
                default: state_bad = 1'b1;
            endcase

            if (line_end) begin
                case (v_state_reg)
                    V_ACT:   if (y_next == Y_FRONT) v_state_next = V_FRONT;
                    V_FRONT: if (y_next == Y_SYNC)  v_state_next = V_SYNC;
                    V_SYNC:  if (y_next == Y_BACK)  v_state_next = V_BACK;
                    V_BACK:  if (y_next == 10'd0)   v_state_next = V_ACT;
                    default: state_bad = 1'b1;
                endcase
            end

            // A corrupted state restarts the raster from the top-left corner.
            if (state_bad) begin
                h_state_next = H_ACT;
                v_state_next = V_ACT;
                x_next       = 10'd0;
                y_next       = 10'd0;
                frame_wrap   = 1'b0;
            end
        end
    end

    // Syncs and blank are decoded from the next state so they line up with the new DrawX/DrawY.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pclk_reg        <= 1'b0;
            h_state_reg     <= H_ACT;
            v_state_reg     <= V_ACT;
            x_reg           <= 10'd0;
            y_reg           <= 10'd0;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            blank_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            pclk_reg        <= ~pclk_reg;
            h_state_reg     <= h_state_next;
            v_state_reg     <= v_state_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            hs_reg          <= (h_state_next != H_SYNC);
            vs_reg          <= (v_state_next != V_SYNC);
            blank_reg       <= (h_state_next == H_ACT) && (v_state_next == V_ACT);
            frame_start_reg <= frame_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count_reg;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            frame_count_reg <= 8'd0;
        else if (frame_wrap)
            frame_count_reg <= frame_count_reg + 8'd1;
    end
    assign frame_count = frame_count_reg;
`else
    assign frame_count = 8'd0;
`endif

    assign pixel_clk   = pclk_reg;
    assign hs          = hs_reg;
    assign vs          = vs_reg;
    assign blank       = blank_reg;
    assign sync        = 1'b0;
    assign DrawX       = x_reg;
    assign DrawY       = y_reg;
    assign frame_start = frame_start_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a tiny-raster instance checked cycle by cycle against an
// arithmetic raster model, plus a default-parameter instance for real 640x480 line timing.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    localparam int SH_VIS = 8, SH_FP = 1, SH_SW = 2, SH_BP = 1;
    localparam int SV_VIS = 4, SV_FP = 1, SV_SW = 1, SV_BP = 2;
    localparam int S_FRAME_CLK = 2 * (SH_VIS + SH_FP + SH_SW + SH_BP) * (SV_VIS + SV_FP + SV_SW + SV_BP);
    localparam logic [33:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0, 10'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       s_pclk, s_hs, s_vs, s_blank, s_sync, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;
    logic       d_pclk, d_hs, d_vs, d_blank, d_sync, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;
    logic [33:0] s_obs, d_obs;
    assign s_obs = {s_pclk, s_hs, s_vs, s_blank, s_sync, s_fs, s_fc, s_y, s_x};
    assign d_obs = {d_pclk, d_hs, d_vs, d_blank, d_sync, d_fs, d_fc, d_y, d_x};

    vga_timing_gen #(
        .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SW(SH_SW), .H_BP(SH_BP),
        .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SW(SV_SW), .V_BP(SV_BP)
    ) dut_small (
        .Clk(clk), .Reset(rst), .pixel_clk(s_pclk), .hs(s_hs), .vs(s_vs), .blank(s_blank),
        .sync(s_sync), .DrawX(s_x), .DrawY(s_y), .frame_start(s_fs), .frame_count(s_fc)
    );

    vga_timing_gen dut_def (
        .Clk(clk), .Reset(rst), .pixel_clk(d_pclk), .hs(d_hs), .vs(d_vs), .blank(d_blank),
        .sync(d_sync), .DrawX(d_x), .DrawY(d_y), .frame_start(d_fs), .frame_count(d_fc)
    );

    // Clk edges seen since reset release; the model derives everything from this number.
    int n;
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    int checks = 0;
    int passed = 0;

    function automatic logic [33:0] model(input int edges, input int hv, input int hfp, input int hsw,
                                          input int hbp, input int vv, input int vfp, input int vsw,
                                          input int vbp);
        int htot = hv + hfp + hsw + hbp;
        int fpix = htot * (vv + vfp + vsw + vbp);
        int a    = edges / 2;
        int p    = a % fpix;
        int x    = p % htot;
        int y    = p / htot;
        logic pc = (edges % 2) == 1;
        logic h  = !(x >= hv + hfp && x < hv + hfp + hsw);
        logic v  = !(y >= vv + vfp && y < vv + vfp + vsw);
        logic bl = (edges > 0) && (x < hv) && (y < vv);
        logic fs = (edges % 2 == 0) && (a > 0) && (p == 0);
        logic [7:0] fc;
`ifdef VGA_FRAME_COUNT_EN
        fc = 8'((a / fpix) % 256);
`else
        fc = 8'd0;
`endif
        return {pc, h, v, bl, 1'b0, fs, fc, 10'(y), 10'(x)};
    endfunction

    function automatic logic [33:0] model_small(input int edges);
        return model(edges, SH_VIS, SH_FP, SH_SW, SH_BP, SV_VIS, SV_FP, SV_SW, SV_BP);
    endfunction

    function automatic logic [33:0] model_def(input int edges);
        return model(edges, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (s_obs !== RST_VEC) $display("FAIL reset_small got %h expected %h", s_obs, RST_VEC);
            else passed++;
            checks++;
            if (d_obs !== RST_VEC) $display("FAIL reset_default got %h expected %h", d_obs, RST_VEC);
            else passed++;
        end
        $display("test_reset done");
    endtask

    task automatic test_release();
        logic [33:0] es, ed;
        logic [9:0]  x0, y0;
        logic        pc0;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_blank !== 1'b1 || s_pclk !== 1'b1 || s_x !== 10'd0)
            $display("FAIL release_edge1 got blank=%b pclk=%b x=%0d expected 1 1 0", s_blank, s_pclk, s_x);
        else passed++;
        @(negedge clk);
        checks++;
        if (s_x !== 10'd1 || s_pclk !== 1'b0)
            $display("FAIL release_edge2 got x=%0d pclk=%b expected 1 0", s_x, s_pclk);
        else passed++;
        for (int i = 0; i < 3500; i++) begin
            @(negedge clk);
            es = model_small(n);
            ed = model_def(n);
            checks++;
            if (s_obs !== es) $display("FAIL release_small n=%0d got %h expected %h", n, s_obs, es);
            else passed++;
            checks++;
            if (d_obs !== ed) $display("FAIL release_default n=%0d got %h expected %h", n, d_obs, ed);
            else passed++;
            x0 = s_x; y0 = s_y; pc0 = s_pclk;
            @(posedge clk); #1;
            if (!pc0 && s_pclk) begin
                checks++;
                if (s_x !== x0 || s_y !== y0)
                    $display("FAIL pclk_rise_stable got (%0d,%0d) expected (%0d,%0d)", s_x, s_y, x0, y0);
                else passed++;
            end
        end
        $display("test_release done n=%0d", n);
    endtask

    task automatic test_mid_reset();
        int budget = 0;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        while (!(s_x == 10'd5 && s_y == 10'd3) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (budget >= 1000) $display("FAIL mid_reset_reach got timeout expected (5,3)");
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (s_obs !== RST_VEC) $display("FAIL mid_reset_small got %h expected %h", s_obs, RST_VEC);
        else passed++;
        checks++;
        if (d_obs !== RST_VEC) $display("FAIL mid_reset_default got %h expected %h", d_obs, RST_VEC);
        else passed++;
        $display("test_mid_reset done");
    endtask

    task automatic test_hsync_default();
        int falls = 0;
        int fall_n = 0;
        logic prev_hs = 1'b1;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3400; i++) begin
            @(negedge clk);
            if (prev_hs && !d_hs) begin
                checks++;
                if (d_x !== 10'd656) $display("FAIL hs_fall_x got %0d expected 656", d_x);
                else passed++;
                if (falls > 0) begin
                    checks++;
                    if (n - fall_n !== 1600) $display("FAIL hs_period got %0d expected 1600", n - fall_n);
                    else passed++;
                end
                falls++;
                fall_n = n;
            end
            if (!prev_hs && d_hs) begin
                checks++;
                if (n - fall_n !== 192) $display("FAIL hs_low_width got %0d expected 192", n - fall_n);
                else passed++;
            end
            prev_hs = d_hs;
        end
        checks++;
        if (falls < 2) $display("FAIL hs_fall_count got %0d expected 2", falls);
        else passed++;
        $display("test_hsync_default done falls=%0d", falls);
    endtask

    task automatic test_random_resets();
        logic [33:0] es;
        for (int it = 0; it < 6; it++) begin
            int run = $urandom_range(50, 600);
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < run; i++) begin
                @(negedge clk);
                es = model_small(n);
                checks++;
                if (s_obs !== es) $display("FAIL random_small n=%0d got %h expected %h", n, s_obs, es);
                else passed++;
            end
            #($urandom_range(1, 8)) rst = 1'b1;
            #0.5;
            checks++;
            if (s_obs !== RST_VEC) $display("FAIL random_async_reset got %h expected %h", s_obs, RST_VEC);
            else passed++;
            $display("test_random_resets iter=%0d run=%0d", it, run);
        end
    endtask

    task automatic test_frame_wrap();
        logic [33:0] es;
        int fs_seen = 0;
        int blank_cnt = 0;
        int last_n = 0;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 256 * S_FRAME_CLK + 200; i++) begin
            @(negedge clk);
            es = model_small(n);
            checks++;
            if (s_obs !== es) $display("FAIL frame_small n=%0d got %h expected %h", n, s_obs, es);
            else passed++;
            if (s_fs) begin
                fs_seen++;
                if (fs_seen == 256) begin
                    checks++;
                    if (s_fc !== 8'd0) $display("FAIL frame_count_wrap got %0d expected 0", s_fc);
                    else passed++;
                end
            end
            if (n >= S_FRAME_CLK && n < 2 * S_FRAME_CLK && s_blank) blank_cnt++;
            last_n = n;
        end
        checks++;
        if (fs_seen !== (last_n / 2) / (S_FRAME_CLK / 2))
            $display("FAIL frame_start_count got %0d expected %0d", fs_seen, (last_n / 2) / (S_FRAME_CLK / 2));
        else passed++;
        checks++;
        if (blank_cnt !== 2 * SH_VIS * SV_VIS)
            $display("FAIL blank_per_frame got %0d expected %0d", blank_cnt, 2 * SH_VIS * SV_VIS);
        else passed++;
        $display("test_frame_wrap done frames=%0d", fs_seen);
    endtask

    initial begin
        test_reset();
        test_release();
        test_mid_reset();
        test_hsync_default();
        test_random_resets();
        test_frame_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
